// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants for the multiplexed seven-segment driver
//
// Contents:
//   SEG_A / SEG_G / SEG_DP : bit positions inside an 8-bit segment pattern
//                            (bits [6:0] = gfedcba, bit 7 = decimal point)
//   SEG_OFF                : active-low "everything dark" pattern
//   SEG_LUT                : 16-entry hex glyph table, active-high gfedcba
//   seg_lookup()           : nibble -> active-high gfedcba glyph
package ss_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry n occupies bits [7n+6:7n]; entry 0 is at the right-hand end.
  localparam logic [16*7-1:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic seg_t seg_lookup(input logic [3:0] nib);
    return SEG_LUT[int'(nib)*7 +: 7];
  endfunction

endpackage

// File: rtl/ss_hex_decoder.sv
// rtl/ss_hex_decoder.sv - hex nibble to active-high gfedcba segment decoder
//
// Ports:
//   i_nibble   : 4-bit hex value 0..F
//   o_segments : active-high segments, [6:0] = gfedcba
module ss_hex_decoder
  import ss_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  assign o_segments = seg_lookup(i_nibble);

endmodule

// File: rtl/ss_mux_driver.sv
// rtl/ss_mux_driver.sv - multiplexed common-anode seven-segment scan driver
//
// Scans DIGITS digits from packed hex nibbles, one slot of 2^DIV_W clocks per
// digit, with decimal points, leading-zero blanking, blink, PWM brightness
// and a double-buffered data path so a frame never mixes old and new values.
//
// Ports:
//   Clk            : system clock
//   Reset          : synchronous, active-high
//   Digits         : packed hex nibbles, digit 0 = [3:0] (rightmost)
//   DotIn          : per-digit decimal point enable
//   BlankMask      : per-digit force dark
//   BlinkMask      : per-digit blink enable
//   LeadZeroBlank  : leading-zero suppression enable
//   Load           : one-cycle strobe capturing the data inputs above
//   Brightness     : PWM duty = (Brightness+1)/2^BRIGHT_W, applied live
//   SegmentDrivers : digit enables, active low
//   SevenSegment   : [6:0] = gfedcba, [7] = DP, active low
//   FrameStart     : one-cycle pulse on the first output cycle of digit 0
//   Pending        : loaded data waiting for the next frame boundary
module ss_mux_driver
  import ss_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV_W    = 17,
  parameter int BRIGHT_W = 4,
  parameter int BLINK_W  = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Digits,
  input  logic [DIGITS-1:0]     DotIn,
  input  logic [DIGITS-1:0]     BlankMask,
  input  logic [DIGITS-1:0]     BlinkMask,
  input  logic                  LeadZeroBlank,
  input  logic                  Load,
  input  logic [BRIGHT_W-1:0]   Brightness,
  output logic [DIGITS-1:0]     SegmentDrivers,
  output logic [7:0]            SevenSegment,
  output logic                  FrameStart,
  output logic                  Pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  // ---------------------------------------------------------------------
  // Scan timing: prescaler, digit index, frame counter
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0]   r_count;
  logic [IDX_W-1:0]   r_index;
  logic [BLINK_W-1:0] r_frame;
  logic               r_wrapped;

  logic w_tick;
  logic w_wrap;

  assign w_tick = &r_count;
  assign w_wrap = w_tick && (r_index == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count   <= '0;
      r_index   <= '0;
      r_frame   <= '0;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= r_count + DIV_W'(1);
      // The wrap edge moves the index to digit 0; the output stage shows
      // that digit one edge later, so FrameStart is taken from this flag.
      r_wrapped <= w_wrap;
      if (w_wrap) begin
        r_index <= '0;
        r_frame <= r_frame + BLINK_W'(1);
      end else if (w_tick) begin
        r_index <= r_index + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Double buffer: Load fills pending, the frame wrap promotes it
  // ---------------------------------------------------------------------
  logic [4*DIGITS-1:0] r_pend_digits;
  logic [DIGITS-1:0]   r_pend_dot;
  logic [DIGITS-1:0]   r_pend_blank;
  logic [DIGITS-1:0]   r_pend_blink;
  logic                r_pend_lzb;
  logic                r_pending;

  logic [4*DIGITS-1:0] r_act_digits;
  logic [DIGITS-1:0]   r_act_dot;
  logic [DIGITS-1:0]   r_act_blank;
  logic [DIGITS-1:0]   r_act_blink;
  logic                r_act_lzb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pend_digits <= '0;
      r_pend_dot    <= '0;
      r_pend_blank  <= '0;
      r_pend_blink  <= '0;
      r_pend_lzb    <= 1'b0;
      r_pending     <= 1'b0;
      r_act_digits  <= '0;
      r_act_dot     <= '0;
      r_act_blank   <= '0;
      r_act_blink   <= '0;
      r_act_lzb     <= 1'b0;
    end else begin
      // Promotion reads the pending regs before this edge's Load lands, so
      // a Load on the wrap edge is queued for the following frame.
      if (w_wrap && r_pending) begin
        r_act_digits <= r_pend_digits;
        r_act_dot    <= r_pend_dot;
        r_act_blank  <= r_pend_blank;
        r_act_blink  <= r_pend_blink;
        r_act_lzb    <= r_pend_lzb;
      end
      if (Load) begin
        r_pend_digits <= Digits;
        r_pend_dot    <= DotIn;
        r_pend_blank  <= BlankMask;
        r_pend_blink  <= BlinkMask;
        r_pend_lzb    <= LeadZeroBlank;
        r_pending     <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero map: a digit is suppressed while every digit from the top
  // down to it is zero; digit 0 always shows.
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] w_lz_blank;
  logic              w_zero_above;

  always_comb begin
    w_lz_blank   = '0;
    w_zero_above = r_act_lzb;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_zero_above  = w_zero_above && (r_act_digits[4*d +: 4] == 4'h0);
      w_lz_blank[d] = w_zero_above;
    end
  end

  // ---------------------------------------------------------------------
  // Select the attributes of the digit currently being scanned
  // ---------------------------------------------------------------------
  logic [3:0]        w_nibble;
  logic              w_sel_dot;
  logic              w_sel_blank;
  logic              w_sel_blink;
  logic              w_sel_lz;
  logic [DIGITS-1:0] w_onehot;

  always_comb begin
    w_nibble    = 4'h0;
    w_sel_dot   = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_blink = 1'b0;
    w_sel_lz    = 1'b0;
    w_onehot    = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_index == IDX_W'(d)) begin
        w_nibble    = r_act_digits[4*d +: 4];
        w_sel_dot   = r_act_dot[d];
        w_sel_blank = r_act_blank[d];
        w_sel_blink = r_act_blink[d];
        w_sel_lz    = w_lz_blank[d];
        w_onehot[d] = 1'b1;
      end
    end
  end

  logic [6:0] w_glyph;

  ss_hex_decoder u_decoder (
    .i_nibble   (w_nibble),
    .o_segments (w_glyph)
  );

  // ---------------------------------------------------------------------
  // Dark / DP / PWM decisions
  // ---------------------------------------------------------------------
  logic       w_blink_off;
  logic       w_dark;
  logic       w_dp;
  logic       w_enable;
  logic       w_window;
  logic [7:0] w_pattern;

  // Blink hides segments and DP; a leading-zero digit keeps its DP.
  assign w_blink_off = w_sel_blink && r_frame[BLINK_W-1];
  assign w_dark      = w_sel_blank || w_sel_lz || w_blink_off;
  assign w_dp        = w_sel_dot && !w_sel_blank && !w_blink_off;
  // A dark digit only needs its anode when the DP is lit.
  assign w_enable    = !w_dark || w_dp;
  assign w_window    = (r_count[DIV_W-1 -: BRIGHT_W] <= Brightness);

  always_comb begin
    w_pattern                = '0;
    w_pattern[SEG_G:SEG_A]   = w_dark ? 7'h00 : w_glyph;
    w_pattern[SEG_DP]        = w_dp;
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [DIGITS-1:0] r_drivers;
  logic [7:0]        r_segments;
  logic              r_frame_start;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_drivers     <= '1;
      r_segments    <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_drivers     <= (w_window && w_enable) ? ~w_onehot : '1;
      r_segments    <= w_window ? ~w_pattern : SEG_OFF;
      r_frame_start <= r_wrapped;
    end
  end

  assign SegmentDrivers = r_drivers;
  assign SevenSegment   = r_segments;
  assign FrameStart     = r_frame_start;
  assign Pending        = r_pending;

endmodule

// File: tb/tb_ss_mux_driver.sv
// tb/tb_ss_mux_driver.sv - scoreboard bench for the seven-segment scan driver
module tb_ss_mux_driver;

  localparam int DIGITS   = 4;
  localparam int DIV_W    = 4;
  localparam int BRIGHT_W = 2;
  localparam int BLINK_W  = 2;
  localparam int FRAME    = 64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Digits = '0;
  logic [3:0]  DotIn = '0;
  logic [3:0]  BlankMask = '0;
  logic [3:0]  BlinkMask = '0;
  logic        LeadZeroBlank = 1'b0;
  logic        Load = 1'b0;
  logic [1:0]  Brightness = 2'd3;
  logic [3:0]  SegmentDrivers;
  logic [7:0]  SevenSegment;
  logic        FrameStart;
  logic        Pending;

  int n_checks = 0;
  int n_fail   = 0;

  // {Pending, FrameStart, SegmentDrivers, SevenSegment}
  logic [13:0] sb[$];

  ss_mux_driver #(
    .DIGITS(DIGITS), .DIV_W(DIV_W), .BRIGHT_W(BRIGHT_W), .BLINK_W(BLINK_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Digits(Digits), .DotIn(DotIn),
    .BlankMask(BlankMask), .BlinkMask(BlinkMask), .LeadZeroBlank(LeadZeroBlank),
    .Load(Load), .Brightness(Brightness), .SegmentDrivers(SegmentDrivers),
    .SevenSegment(SevenSegment), .FrameStart(FrameStart), .Pending(Pending)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {FrameStart, drivers, segments} for cycle i (0..63) of a frame.
  function automatic logic [12:0] model_out(input logic [15:0] d, input logic [3:0] dot,
      input logic [3:0] blk, input logic [3:0] blm, input logic lzb, input int br,
      input int frame, input int i);
    int slot, cyc;
    logic [3:0] nib, drv;
    logic lzbl, phase, dark, dp;
    logic [6:0] seg;
    logic [7:0] so;
    slot  = i / 16;
    cyc   = i % 16;
    nib   = d[slot*4 +: 4];
    lzbl  = lzb && (slot != 0) && ((d >> (4*slot)) == 16'h0);
    phase = ((frame / 2) % 2) == 1;
    dark  = blk[slot] || lzbl || (blm[slot] && phase);
    dp    = dot[slot] && !blk[slot] && !(blm[slot] && phase);
    seg   = dark ? 7'h00 : seg7(nib);
    if ((cyc / 4) > br) begin
      drv = 4'hF;
      so  = 8'hFF;
    end else begin
      drv = (!dark || dp) ? ~(4'b0001 << slot) : 4'hF;
      so  = ~{dp, seg};
    end
    return {(i == 0), drv, so};
  endfunction

  task automatic wait_fs();
    int k;
    for (k = 0; k < 200 && FrameStart !== 1'b1; k++) @(negedge Clk);
    n_checks++;
    if (FrameStart !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_fs: FrameStart=%b after %0d cycles, required 1", FrameStart, k);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++;
    if (SegmentDrivers !== 4'hF) begin n_fail++; $display("FAIL reset_drivers: got %h required f", SegmentDrivers); end
    n_checks++;
    if (SevenSegment !== 8'hFF) begin n_fail++; $display("FAIL reset_segments: got %h required ff", SevenSegment); end
    n_checks++;
    if (Pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b required 0", Pending); end
    n_checks++;
    if (FrameStart !== 1'b0) begin n_fail++; $display("FAIL reset_framestart: got %b required 0", FrameStart); end
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (SegmentDrivers !== 4'hE) begin n_fail++; $display("FAIL release_drivers: got %h required e", SegmentDrivers); end
    n_checks++;
    if (SevenSegment !== 8'hC0) begin n_fail++; $display("FAIL release_segments: got %h required c0", SevenSegment); end
  endtask

  task automatic test_decode();
    logic [3:0] drv_t[4];
    logic [7:0] seg_t[4];
    logic [13:0] exp, got;
    int k;
    drv_t = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_t = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    wait_fs();
    Digits = 16'h12AF; DotIn = '0; BlankMask = '0; BlinkMask = '0; LeadZeroBlank = 1'b0;
    Brightness = 2'd3; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    n_checks++;
    if (Pending !== 1'b1) begin n_fail++; $display("FAIL decode_pending_set: got %b required 1", Pending); end
    wait_fs();
    for (int i = 0; i < FRAME; i++) sb.push_back({1'b0, (i == 0), drv_t[i/16], seg_t[i/16]});
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL decode cycle %0d: got %h required %h", k, got, exp); end
      k++;
      @(negedge Clk);
    end
  endtask

  task automatic test_lzb_dots();
    logic [15:0] d_t[4];
    logic [3:0]  dot_t[4];
    logic [3:0]  blk_t[4];
    logic        lzb_t[4];
    logic [3:0]  drv_t[4][4];
    logic [7:0]  seg_t[4][4];
    logic [13:0] exp, got;
    int k;
    d_t   = '{16'h0070, 16'h0000, 16'h1002, 16'h8000};
    dot_t = '{4'b0100, 4'b0000, 4'b0000, 4'b1001};
    blk_t = '{4'b0000, 4'b0000, 4'b0010, 4'b0000};
    lzb_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    drv_t = '{'{4'hE, 4'hD, 4'hB, 4'hF}, '{4'hE, 4'hF, 4'hF, 4'hF},
              '{4'hE, 4'hF, 4'hB, 4'h7}, '{4'hE, 4'hD, 4'hB, 4'h7}};
    seg_t = '{'{8'hC0, 8'hF8, 8'h7F, 8'hFF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF},
              '{8'hA4, 8'hFF, 8'hC0, 8'hF9}, '{8'h40, 8'hC0, 8'hC0, 8'h00}};
    for (int p = 0; p < 4; p++) begin
      wait_fs();
      Digits = d_t[p]; DotIn = dot_t[p]; BlankMask = blk_t[p]; BlinkMask = '0;
      LeadZeroBlank = lzb_t[p]; Brightness = 2'd3; Load = 1'b1;
      @(negedge Clk);
      Load = 1'b0;
      wait_fs();
      for (int i = 0; i < FRAME; i++) sb.push_back({1'b0, (i == 0), drv_t[p][i/16], seg_t[p][i/16]});
      k = 0;
      while (sb.size() > 0) begin
        exp = sb.pop_front();
        got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL lzb pattern %0d cycle %0d: got %h required %h", p, k, got, exp); end
        k++;
        @(negedge Clk);
      end
    end
  endtask

  task automatic test_brightness();
    logic [13:0] exp, got;
    int on_cnt[4];
    int k;
    for (int br = 0; br < 3; br++) begin
      wait_fs();
      Digits = 16'h0000; DotIn = '0; BlankMask = '0; BlinkMask = '0; LeadZeroBlank = 1'b0;
      Brightness = 2'(br); Load = 1'b1;
      @(negedge Clk);
      Load = 1'b0;
      wait_fs();
      for (int i = 0; i < FRAME; i++) sb.push_back({1'b0, model_out(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, br, 0, i)});
      on_cnt = '{0, 0, 0, 0};
      k = 0;
      while (sb.size() > 0) begin
        exp = sb.pop_front();
        got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
        if (SegmentDrivers[k/16] === 1'b0) on_cnt[k/16]++;
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL bright %0d cycle %0d: got %h required %h", br, k, got, exp); end
        k++;
        @(negedge Clk);
      end
      for (int s = 0; s < 4; s++) begin
        n_checks++;
        if (on_cnt[s] != 4 * (br + 1)) begin
          n_fail++;
          $display("FAIL bright %0d digit %0d on-cycles: got %0d required %0d", br, s, on_cnt[s], 4 * (br + 1));
        end
      end
    end
    Brightness = 2'd3;
  endtask

  task automatic test_load_mid_frame();
    logic [13:0] exp, got;
    logic pend;
    int k;
    wait_fs();
    Digits = 16'h4321; DotIn = '0; BlankMask = '0; BlinkMask = '0; LeadZeroBlank = 1'b0;
    Brightness = 2'd3; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    wait_fs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      pend = (i >= 21) && (i <= 62);
      sb.push_back({pend, model_out((i < FRAME) ? 16'h4321 : 16'h9876, 4'h0, 4'h0, 4'h0, 1'b0, 3, 0, i % FRAME)});
    end
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL load_mid cycle %0d: got %h required %h", k, got, exp); end
      if (k == 20) begin
        Digits = 16'h9876;
        Load = 1'b1;
      end else begin
        Load = 1'b0;
      end
      k++;
      @(negedge Clk);
    end
    Load = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    logic [13:0] exp, got;
    logic [15:0] val;
    logic pend;
    int k;
    wait_fs();
    Digits = 16'h5555; DotIn = '0; BlankMask = '0; BlinkMask = '0; LeadZeroBlank = 1'b0;
    Brightness = 2'd3; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    wait_fs();
    for (int i = 0; i < 3 * FRAME; i++) begin
      val  = (i < FRAME) ? 16'h5555 : ((i < 2 * FRAME) ? 16'hABCD : 16'hDEF0);
      pend = (i >= 31) && (i <= 126);
      sb.push_back({pend, model_out(val, 4'h0, 4'h0, 4'h0, 1'b0, 3, 0, i % FRAME)});
    end
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL load_wrap cycle %0d: got %h required %h", k, got, exp); end
      if (k == 30) begin
        Digits = 16'hABCD; Load = 1'b1;
      end else if (k == 62) begin
        Digits = 16'hDEF0; Load = 1'b1;
      end else begin
        Load = 1'b0;
      end
      k++;
      @(negedge Clk);
    end
    Load = 1'b0;
  endtask

  task automatic test_blink();
    logic [13:0] exp, got;
    int k;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    Digits = 16'h0000; DotIn = '0; BlankMask = '0; BlinkMask = 4'b0001; LeadZeroBlank = 1'b0;
    Brightness = 2'd3; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    wait_fs();
    // First FrameStart after reset begins frame counter value 1.
    for (int i = 0; i < 4 * FRAME; i++)
      sb.push_back({1'b0, model_out(16'h0000, 4'h0, 4'h0, 4'b0001, 1'b0, 3, (1 + i / FRAME) % 4, i % FRAME)});
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL blink cycle %0d: got %h required %h", k, got, exp); end
      k++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [13:0] exp, got;
    logic [12:0] m;
    int k;
    wait_fs();
    Digits = 16'h7777; DotIn = '0; BlankMask = '0; BlinkMask = '0; LeadZeroBlank = 1'b0;
    Brightness = 2'd3; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    repeat (4) @(negedge Clk);
    n_checks++;
    if (Pending !== 1'b1) begin n_fail++; $display("FAIL midreset_pending_before: got %b required 1", Pending); end
    Reset = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (SegmentDrivers !== 4'hF) begin n_fail++; $display("FAIL midreset_drivers: got %h required f", SegmentDrivers); end
    n_checks++;
    if (SevenSegment !== 8'hFF) begin n_fail++; $display("FAIL midreset_segments: got %h required ff", SevenSegment); end
    n_checks++;
    if (Pending !== 1'b0) begin n_fail++; $display("FAIL midreset_pending: got %b required 0", Pending); end
    n_checks++;
    if (FrameStart !== 1'b0) begin n_fail++; $display("FAIL midreset_framestart: got %b required 0", FrameStart); end
    Reset = 1'b0;
    @(negedge Clk);
    // The scan restarting from reset carries no FrameStart; the first wrap does.
    for (int i = 0; i <= FRAME; i++) begin
      m = model_out(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 3, 0, i % FRAME);
      if (i < FRAME) m[12] = 1'b0;
      sb.push_back({1'b0, m});
    end
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {Pending, FrameStart, SegmentDrivers, SevenSegment};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midreset_after cycle %0d: got %h required %h", k, got, exp); end
      k++;
      @(negedge Clk);
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_decode();
    test_lzb_dots();
    test_brightness();
    test_load_mid_frame();
    test_load_on_wrap();
    test_blink();
    test_reset_mid_slot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
